tcm_loader: RTL

- Byte-stream program loader: the writing end of the CPU's ITCM/DTCM.
- Receives framed commands over a valid/ready byte interface, typically from a UART receiver or a host bench driver.
- Assembles little-endian 32-bit words, writes them into the instruction or data TCM, then sets the reset PC and releases the core.
- Replaces $readmemh/hierarchical preload, so the same images run on FPGA.

---
 rtl/tcm_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tcm_loader.sv
// Byte-stream loader for the CPU's ITCM/DTCM: assembles framed little-endian
// words into TCM writes, then sets the reset PC and releases the core.
module tcm_loader #(
    parameter int          ADDR_W   = 14,
    parameter logic [7:0]  CMD_IMEM = 8'h01,
    parameter logic [7:0]  CMD_DMEM = 8'h02,
    parameter logic [7:0]  CMD_GO   = 8'h03,
    parameter logic [7:0]  CMD_HALT = 8'h04
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic [31:0]       reset_pc,
    output logic              err,
    output logic [15:0]       words_written
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_PC    = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [15:0]       len_q, len_d;
    logic              tgt_q, tgt_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [31:0]       reset_pc_q, reset_pc_d;
    logic              err_q, err_d;
    logic [15:0]       words_q, words_d;

    logic        accept;
    logic [31:0] word_in;

    assign accept  = rx_valid & rx_ready_q;
    // Bytes enter at the top and shift down, so after four bytes the word is little-endian.
    assign word_in = {rx_data, shift_q[31:8]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        len_d       = len_q;
        tgt_d       = tgt_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        reset_pc_d  = reset_pc_q;
        err_d       = err_q;
        words_d     = words_q;

        case (state_q)
            S_IDLE: if (accept) begin
                cnt_d = 2'd0;
                if (rx_data == CMD_IMEM || rx_data == CMD_DMEM) begin
                    tgt_d   = (rx_data == CMD_DMEM);
                    state_d = S_ADDR;
                end else if (rx_data == CMD_GO) begin
                    state_d = S_PC;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_ADDR: if (accept) begin
                shift_d = word_in;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    mem_addr_d = word_in[ADDR_W+1:2];
                    state_d    = S_LEN;
                end
            end
            S_LEN: if (accept) begin
                shift_d = word_in;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = 2'd0;
                    len_d   = word_in[31:16];
                    state_d = (word_in[31:16] == 16'd0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (accept) begin
                shift_d = word_in;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    mem_wdata_d = word_in;
                    imem_we_d   = ~tgt_q;
                    dmem_we_d   = tgt_q;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address advances after the strobe so it is stable while we is high.
                mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                len_d   = len_q - 16'd1;
                state_d = (len_q == 16'd1) ? S_IDLE : S_DATA;
            end
            S_PC: if (accept) begin
                shift_d = word_in;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    reset_pc_d = word_in;
                    cpu_hold_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: if (accept && rx_data == CMD_HALT) begin
                cpu_hold_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            shift_q     <= 32'd0;
            len_q       <= 16'd0;
            tgt_q       <= 1'b0;
            rx_ready_q  <= 1'b1;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            reset_pc_q  <= 32'd0;
            err_q       <= 1'b0;
            words_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            tgt_q       <= tgt_d;
            rx_ready_q  <= rx_ready_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            reset_pc_q  <= reset_pc_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign imem_we       = imem_we_q;
    assign dmem_we       = dmem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign reset_pc      = reset_pc_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule
